// File: rtl/serial_add_sub_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor.
// The master issues operations; the slave (the serial unit) returns results.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b, bin,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, mode, a, b, bin,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-add/full-subtract cell plus a carry/borrow
// flop, one bit per clock, LSB first, with carry/borrow-out and signed overflow.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_add_sub_if.slave     bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             msb_cin_q, msb_cin_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             ai, bi, bit_out, carry_out;
    logic [WIDTH-1:0] work_shifted;

    // Shared bit cell: sum and difference bits are identical, only the carry term differs.
    always_comb begin
        ai           = a_q[0];
        bi           = b_q[0];
        bit_out      = ai ^ bi ^ carry_q;
        carry_out    = mode_q ? ((ai & bi) | (carry_q & (ai ^ bi)))
                              : ((~ai & bi) | (~(ai ^ bi) & carry_q));
        work_shifted = {bit_out, work_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    mode_d  = bus.mode;
                    carry_d = bus.bin;
                    cnt_d   = '0;
                    work_d  = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                work_d  = work_shifted;
                carry_d = carry_out;
                cnt_d   = cnt_q + CNT_W'(1);
                // Carry leaving bit WIDTH-2 is the carry into the MSB, needed for overflow.
                if (cnt_q == CNT_W'(WIDTH - 2)) begin
                    msb_cin_d = carry_out;
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d = work_shifted;
                    cout_d   = carry_out;
                    ovf_d    = msb_cin_q ^ carry_out;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            work_q    <= work_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule
